// File: rtl/alu_issue_stage.sv
// Execute-stage issue register ahead of the 64-bit ALU: resolves EX/WB forwarding at capture,
// selects operand B, masks shift amounts, flags illegal opcodes, and holds beats in a main+skid pair.
module alu_issue_stage #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [9:0]        in_opcode,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_use_imm,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              fwd_ex_en,
    input  logic              fwd_wb_en,
    input  logic [REG_AW-1:0] fwd_ex_rd,
    input  logic [REG_AW-1:0] fwd_wb_rd,
    input  logic [DATA_W-1:0] fwd_ex_data,
    input  logic [DATA_W-1:0] fwd_wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [9:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_illegal
);

    // State bit 0 = main register valid, bit 1 = skid register valid.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FULL  = 2'b01;
    localparam logic [1:0] ST_SKID  = 2'b11;

    localparam logic [9:0] OP_ADD = 10'b0100000000;
    localparam logic [9:0] OP_SLL = 10'b0100000001;
    localparam logic [9:0] OP_SRL = 10'b0100000101;

    localparam logic [DATA_W-1:0] SHAMT_MASK = DATA_W'(DATA_W - 1);

    typedef struct packed {
        logic [9:0]        opcode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_AW-1:0] rd;
        logic              illegal;
    } entry_t;

    logic [1:0] state_q, state_d;
    entry_t     m_q, m_d;
    entry_t     s_q, s_d;
    entry_t     cap;

    logic              accept;
    logic              legal;
    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] b_sel;

    // x0 reads as zero regardless of any producer claiming to write it; EX is younger than WB.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [REG_AW-1:0] rs,
        input logic [DATA_W-1:0] rf_data,
        input logic              ex_en,
        input logic [REG_AW-1:0] ex_rd,
        input logic [DATA_W-1:0] ex_data,
        input logic              wb_en,
        input logic [REG_AW-1:0] wb_rd,
        input logic [DATA_W-1:0] wb_data
    );
        if (rs == '0)                  return '0;
        else if (ex_en && ex_rd == rs) return ex_data;
        else if (wb_en && wb_rd == rs) return wb_data;
        else                           return rf_data;
    endfunction

    assign out_valid = state_q[0];
    assign in_ready  = ~state_q[1];
    assign accept    = in_valid && in_ready;

    always_comb begin
        case (in_opcode)
            10'b0100000000, 10'b0100000100, 10'b0100000110, 10'b0100000111,
            10'b0100000001, 10'b0100000101, 10'b1000000000, 10'b1100000000,
            10'b1000000100, 10'b1000000110, 10'b1000000111: legal = 1'b1;
            default:                                         legal = 1'b0;
        endcase
    end

    always_comb begin
        rs1_val = resolve(in_rs1, in_rs1_data, fwd_ex_en, fwd_ex_rd, fwd_ex_data,
                          fwd_wb_en, fwd_wb_rd, fwd_wb_data);
        rs2_val = resolve(in_rs2, in_rs2_data, fwd_ex_en, fwd_ex_rd, fwd_ex_data,
                          fwd_wb_en, fwd_wb_rd, fwd_wb_data);
        b_sel   = in_use_imm ? in_imm : rs2_val;

        cap.opcode  = in_opcode;
        cap.a       = rs1_val;
        cap.b       = b_sel;
        cap.rd      = in_rd;
        cap.illegal = 1'b0;
        if (!legal) begin
            cap.illegal = 1'b1;
            cap.opcode  = OP_ADD;
            cap.a       = '0;
            cap.b       = '0;
        end else if (in_opcode == OP_SLL || in_opcode == OP_SRL) begin
            cap.b = b_sel & SHAMT_MASK;
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_FULL;
                    m_d     = cap;
                end
            end
            ST_FULL: begin
                if (accept && out_ready) begin
                    m_d = cap;
                end else if (accept) begin
                    state_d = ST_SKID;
                    s_d     = cap;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (out_ready) begin
                    state_d = ST_FULL;
                    m_d     = s_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Only the valid bits are killed; stale data left in M/S is never presented.
        if (flush) state_d = ST_EMPTY;
    end

    // NOTE: data registers are reset as well, because the ALU-facing outputs must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            m_q     <= '0;
            s_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge next-state values.
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
        end
    end

    assign alu_opcode  = m_q.opcode;
    assign alu_a       = m_q.a;
    assign alu_b       = m_q.b;
    assign out_rd      = m_q.rd;
    assign out_illegal = m_q.illegal;

endmodule
